// File: rtl/inst_fetch_ctrl.sv
// rtl/inst_fetch_ctrl.sv - IF-stage fetch initiator: PC, ROM ce/addr, IF/ID register.
// Optional fetch counter port fetch_cnt_o enabled by defining FETCH_STAT_EN.
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_inst_i,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
`ifdef FETCH_STAT_EN
  output logic [31:0] fetch_cnt_o,
`endif
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_valid_o
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_inst;
  logic        r_id_valid;
  logic        w_run;
  logic        w_capture;
  logic [31:0] w_flush_pc;
  logic [31:0] w_branch_pc;

  // Targets are word-aligned silently; the low bits are simply dropped.
  assign w_flush_pc  = new_pc_i & ~32'h3;
  assign w_branch_pc = branch_target_i & ~32'h3;
  assign w_run       = (r_state == S_RUN);
  assign w_capture   = w_run && !flush_i && !stall_i;

  assign rom_ce_o   = w_run;
  assign rom_addr_o = r_pc;
  assign id_pc_o    = r_id_pc;
  assign id_inst_o  = r_id_inst;
  assign id_valid_o = r_id_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_id_pc    <= 32'h0;
      r_id_inst  <= 32'h0;
      r_id_valid <= 1'b0;
    end else if (!w_run) begin
      r_state    <= S_RUN;
      r_id_pc    <= 32'h0;
      r_id_inst  <= 32'h0;
      r_id_valid <= 1'b0;
    end else if (flush_i) begin
      r_pc       <= w_flush_pc;
      r_id_pc    <= 32'h0;
      r_id_inst  <= 32'h0;
      r_id_valid <= 1'b0;
    end else if (!stall_i) begin
      // The fetch in flight when a branch is taken is the delay slot.
      r_id_pc    <= r_pc;
      r_id_inst  <= rom_inst_i;
      r_id_valid <= 1'b1;
      r_pc       <= branch_flag_i ? w_branch_pc : (r_pc + PC_STEP);
    end
  end

`ifdef FETCH_STAT_EN
  logic [31:0] r_fetch_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt <= 32'h0;
    end else if (w_capture) begin
      r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

  assign fetch_cnt_o = r_fetch_cnt;
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb/tb_inst_fetch_ctrl.sv - scoreboard bench for inst_fetch_ctrl with directed per-cycle vectors.
module tb_inst_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        stall = 1'b0;
  logic        br = 1'b0;
  logic [31:0] br_tgt = 32'h0;
  logic        flush = 1'b0;
  logic [31:0] new_pc = 32'h0;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
`ifdef FETCH_STAT_EN
  logic [31:0] fetch_cnt;
`endif

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    int          cyc;
    logic        ce;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        v;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc = 0;

  always #5 clk = ~clk;

  inst_fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .rom_ce_o       (rom_ce),
    .rom_addr_o     (rom_addr),
    .rom_inst_i     (rom_inst),
    .stall_i        (stall),
    .branch_flag_i  (br),
    .branch_target_i(br_tgt),
    .flush_i        (flush),
    .new_pc_i       (new_pc),
`ifdef FETCH_STAT_EN
    .fetch_cnt_o    (fetch_cnt),
`endif
    .id_pc_o        (id_pc),
    .id_inst_o      (id_inst),
    .id_valid_o     (id_valid)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == 32'h0)      return 32'h34011100;
    else if (a == 32'h4) return 32'h34020020;
    else                 return 32'h24000000 | {16'h0, a[15:0]};
  endfunction

  assign rom_inst = rom_ce ? rom_word(rom_addr) : 32'h0;

  task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %08h expected %08h", name, c, act, exp);
  endtask

  // Inputs for this cycle plus the outputs expected to be visible during it.
  task automatic step(input logic r, input logic st, input logic b, input logic [31:0] tgt,
                      input logic fl, input logic [31:0] npc,
                      input logic e_ce, input logic [31:0] e_addr, input logic [31:0] e_pc,
                      input logic [31:0] e_inst, input logic e_v, input logic [31:0] e_cnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; stall = st; br = b; br_tgt = tgt; flush = fl; new_pc = npc;
    e.cyc = cyc; e.ce = e_ce; e.addr = e_addr; e.pc = e_pc; e.inst = e_inst; e.v = e_v; e.cnt = e_cnt;
    sb_q.push_back(e);
    cyc++;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check("rom_ce",   mon_e.cyc, {31'h0, rom_ce},   {31'h0, mon_e.ce});
      check("rom_addr", mon_e.cyc, rom_addr,          mon_e.addr);
      check("id_pc",    mon_e.cyc, id_pc,             mon_e.pc);
      check("id_inst",  mon_e.cyc, id_inst,           mon_e.inst);
      check("id_valid", mon_e.cyc, {31'h0, id_valid}, {31'h0, mon_e.v});
`ifdef FETCH_STAT_EN
      check("fetch_cnt", mon_e.cyc, fetch_cnt, mon_e.cnt);
`endif
    end
  end

  initial begin
    //   rst st br tgt           fl npc           ce addr          id_pc         id_inst       v  cnt
    step(1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        0, 0);
    step(1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        0, 0);
    step(1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        0, 0);
    step(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        0, 0);
    step(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        32'h0,        32'h0,        0, 0);
    step(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h4,        32'h0,        32'h34011100, 1, 1);
    step(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h8,        32'h4,        32'h34020020, 1, 2);
    step(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h8,        32'h4,        32'h34020020, 1, 2);
    step(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h8,        32'h4,        32'h34020020, 1, 2);
    step(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'hC,        32'h8,        32'h24000008, 1, 3);
    step(0, 0, 1, 32'h40,       0, 32'h0,        1, 32'h10,       32'hC,        32'h2400000C, 1, 4);
    step(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h40,       32'h10,       32'h24000010, 1, 5);
    step(0, 1, 0, 32'h0,        1, 32'h22,       1, 32'h44,       32'h40,       32'h24000040, 1, 6);
    step(0, 0, 0, 32'h0,        1, 32'hFFFFFFFE, 1, 32'h20,       32'h0,        32'h0,        0, 6);
    step(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'hFFFFFFFC, 32'h0,        32'h0,        0, 6);
    step(0, 1, 1, 32'h80,       0, 32'h0,        1, 32'h0,        32'hFFFFFFFC, 32'h2400FFFC, 1, 7);
    step(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        32'hFFFFFFFC, 32'h2400FFFC, 1, 7);
    step(1, 0, 1, 32'h80,       1, 32'h100,      1, 32'h4,        32'h0,        32'h34011100, 1, 8);
    step(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        0, 0);
    step(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        32'h0,        32'h0,        0, 0);
    step(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h4,        32'h0,        32'h34011100, 1, 1);
    step(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h8,        32'h4,        32'h34020020, 1, 2);
    @(posedge clk);
    @(posedge clk);
    n_total++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
- Instruction-fetch initiator for the OpenMIPS pipeline (IF stage).
- Owns the PC and drives ce/address to the combinational instruction ROM, which returns the instruction in the same cycle.
- Registers {pc, inst, valid} into the IF/ID boundary.
- Applies ctrl stall, branch redirect with one delay slot, and exception flush.

Parameters:
- RESET_PC, 32'h00000000, first fetch address after reset.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous reset, active-high (RstEnable = 1'b1).
- rom_ce_o  out  1  ROM chip enable (ChipEnable = 1).
- rom_addr_o  out  32  byte address to ROM; bits [1:0] always 00.
- rom_inst_i  in  32  ROM data, valid combinationally while rom_ce_o = 1; ZeroWord when ce = 0.
- stall_i  in  1  hold PC and IF/ID outputs.
- branch_flag_i  in  1  redirect request from ID.
- branch_target_i  in  32  redirect address.
- flush_i  in  1  exception/pipeline flush.
- new_pc_i  in  32  flush target (exception vector / EPC).
- id_pc_o  out  32  PC of the instruction held in IF/ID.
- id_inst_o  out  32  instruction held in IF/ID.
- id_valid_o  out  1  IF/ID holds a real instruction.

Behaviour:
- State machine: IDLE (ce = 0) -> RUN (ce = 1). rst forces IDLE. IDLE always moves to RUN on the next edge. RUN stays in RUN until rst.
- Reset values: rom_ce_o = 0, pc = RESET_PC, id_pc_o = 0, id_inst_o = 0, id_valid_o = 0.
- rom_addr_o = pc register, 0 clock latency.
- rom_ce_o = 1 only in RUN. The first fetch of RESET_PC occurs in the cycle after rst drops.
- Per-edge priority in RUN: flush_i > stall_i > branch_flag_i > sequential.
- flush_i = 1:
  - pc <= {new_pc_i[31:2], 2'b00}.
  - id_pc_o, id_inst_o <= 0; id_valid_o <= 0.
  - Takes effect even when stall_i = 1.
- stall_i = 1 (no flush): pc and all id_* hold. ROM address is re-presented unchanged.
- branch_flag_i = 1 (no stall/flush):
  - IF/ID captures the current fetch (pc, rom_inst_i, valid = 1); this is the delay slot.
  - pc <= {branch_target_i[31:2], 2'b00}.
- Sequential: IF/ID captures (pc, rom_inst_i, 1); pc <= pc + PC_STEP, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
- In IDLE, IF/ID captures (0, 0, 0); the ROM is never sampled while ce = 0.
- branch_flag_i during stall is ignored. ID must hold it until stall drops.
- rst mid-operation: all state returns to reset values on that edge regardless of other inputs. Fetch restarts at RESET_PC one cycle after release.
- Misaligned targets are silently aligned; no fault raised.

Optional Feature:
- Macro: FETCH_STAT_EN.
- Defined:
  - Adds output fetch_cnt_o [31:0].
  - Increments by 1 on every edge where IF/ID captures with valid = 1.
  - Holds on stall and flush; cleared by rst; wraps modulo 2^32.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset release: rst = 1 for 3 cycles, then 0 -> ce = 0 in the release cycle. Next cycle ce = 1, addr = 0x0. One cycle later id_pc_o = 0x0, id_inst_o = mem[0], valid = 1.
- Sequential run: ROM holds 0x34011100 at word 0 and 0x34020020 at word 1 -> addresses 0x0, 0x4, 0x8 on consecutive cycles. IF/ID shows those words in order.
- Stall: stall_i = 1 for 2 cycles while addr = 0x8 -> addr stays 0x8 and id_* hold 0x4 / mem[1]. Resumes with 0x8 then 0xC.
- Branch with delay slot: at addr = 0x10, branch_flag_i = 1, target = 0x40 -> IF/ID gets pc 0x10 (delay slot). Next addr = 0x40, then 0x44.
- Flush vs stall: stall_i = 1 and flush_i = 1 with new_pc_i = 0x20 simultaneously -> next addr = 0x20, id_valid_o = 0, id_inst_o = 0. Target 0x22 yields addr 0x20.
- Wrap and stat: pc forced to 0xFFFFFFFC via flush -> next addr 0x0. With FETCH_STAT_EN, fetch_cnt_o = 5 after 5 unstalled fetches and is unchanged across the flush cycle.
